// File: rtl/pc_pkg.sv
// pc_pkg: shared select encoding and constants for the fetch-stage PC sequencer
package pc_pkg;
  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JREG} pc_sel_t;
  localparam int INSTR_BYTES = 4;
  localparam int JUMP_REGION_W = 28;
endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] pushData,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, topIdx;
  logic [CW-1:0] count;
  assign topIdx = ptr - PW'(1);
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign top = empty ? '0 : mem[topIdx];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      count <= '0;
    end else if (pop) begin
      if (!empty) begin
        ptr <= topIdx;
        count <= count - CW'(1);
      end
    end else if (push) begin
      ptr <= ptr + PW'(1);
      count <= full ? count : count + CW'(1);
    end
  always_ff @(posedge clk)
    if (push && !pop) mem[ptr] <= pushData;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS32 next-PC generator with stall, reset vector and return-address stack.
// The RAS only checks JR returns; fetch is always redirected to reg_target.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_eq,
  input  logic              branch_ne,
  input  logic              alu_zero,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic              link,
  input  logic [25:0]       jump_index,
  input  logic              jump_reg,
  input  logic              ret,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ras_mispredict,
  output logic              ras_overflow,
  output logic              ras_underflow
);
  pc_sel_t sel;
  logic taken, push, pop, rasFull;
  logic [ADDR_W-1:0] nextPc, branchTarget, jumpTarget;
  assign taken = (branch_eq & branch_ne) | (branch_eq & alu_zero) | (branch_ne & ~alu_zero);
  assign pc_plus4 = pc + ADDR_W'(INSTR_BYTES);
  assign branchTarget = pc_plus4 + (branch_offset << 2);
  // J/JAL keep the 256 MB region of the delay-slot address
  assign jumpTarget = (pc_plus4 & ~ADDR_W'({JUMP_REGION_W{1'b1}})) | ADDR_W'({jump_index, 2'b00});
  assign push = ~stall & jump & link & ~jump_reg;
  assign pop = ~stall & jump_reg & ret;
  always_comb sel = jump_reg ? PC_JREG : jump ? PC_JUMP : taken ? PC_BRANCH : PC_SEQ;
  always_comb
    nextPc = sel == PC_JREG   ? reg_target :
             sel == PC_JUMP   ? jumpTarget :
             sel == PC_BRANCH ? branchTarget : pc_plus4;
  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .pushData(pc_plus4),
    .top(ras_top),
    .empty(ras_empty),
    .full(rasFull)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_VECTOR;
      ras_mispredict <= 1'b0;
      ras_overflow <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (!stall) pc <= nextPc;
      ras_mispredict <= pop & ~ras_empty & (ras_top != reg_target);
      ras_overflow <= ras_overflow | (push & rasFull);
      ras_underflow <= ras_underflow | (pop & ras_empty);
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (RESET_VECTOR=0x00400000, RAS_DEPTH=4)
module tb_pc_sequencer;
  localparam int W = 32;
  logic clk = 0, rst = 0, stall = 0, branch_eq = 0, branch_ne = 0, alu_zero = 0;
  logic jump = 0, link = 0, jump_reg = 0, ret = 0;
  logic [W-1:0] branch_offset = '0, reg_target = '0;
  logic [25:0] jump_index = '0;
  logic [W-1:0] pc, pc_plus4, ras_top;
  logic ras_empty, ras_mispredict, ras_overflow, ras_underflow;
  int vectors = 0, errors = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] rasQ[$];
  logic [W-1:0] want;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'h0040_0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .alu_zero(alu_zero), .branch_offset(branch_offset), .jump(jump), .link(link),
    .jump_index(jump_index), .jump_reg(jump_reg), .ret(ret), .reg_target(reg_target),
    .pc(pc), .pc_plus4(pc_plus4), .ras_top(ras_top), .ras_empty(ras_empty),
    .ras_mispredict(ras_mispredict), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stall = 0; branch_eq = 0; branch_ne = 0; alu_zero = 0; jump = 0; link = 0;
    jump_reg = 0; ret = 0; branch_offset = '0; reg_target = '0; jump_index = '0;
  endtask

  task automatic jr(input logic [W-1:0] t);
    idle(); jump_reg = 1; reg_target = t; tick(); idle();
  endtask

  task automatic test_reset;
    idle();
    #3 rst = 1;
    #1;
    vectors++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0040_0000); end
    vectors++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", ras_empty); end
    vectors++; if ({ras_mispredict, ras_overflow, ras_underflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {ras_mispredict, ras_overflow, ras_underflow}); end
    @(negedge clk);
    rst = 0;
    expQ.push_back(32'h0040_0004); expQ.push_back(32'h0040_0008); expQ.push_back(32'h0040_000C);
    repeat (3) begin
      tick();
      want = expQ.pop_front();
      vectors++; if (pc !== want) begin errors++; $display("FAIL reset_seq got=%h want=%h", pc, want); end
    end
  endtask

  task automatic test_branch;
    logic [2:0] ctl [5];
    logic [W-1:0] e [5];
    ctl = '{3'b101, 3'b100, 3'b010, 3'b011, 3'b110};
    e = '{32'h0FC, 32'h104, 32'h0FC, 32'h104, 32'h0FC};
    for (int i = 0; i < 5; i++) begin
      jr(32'h100);
      {branch_eq, branch_ne, alu_zero} = ctl[i];
      branch_offset = -32'sd2;
      expQ.push_back(e[i]);
      tick(); idle();
      want = expQ.pop_front();
      vectors++; if (pc !== want) begin errors++; $display("FAIL branch_%0d got=%h want=%h", i, pc, want); end
    end
  endtask

  task automatic test_jal_ret;
    jr(32'h1000);
    jump = 1; link = 1; jump_index = 26'h40;
    expQ.push_back(32'h100);
    tick(); idle();
    want = expQ.pop_front();
    vectors++; if (pc !== want) begin errors++; $display("FAIL jal_pc got=%h want=%h", pc, want); end
    vectors++; if (ras_top !== 32'h1004) begin errors++; $display("FAIL jal_top got=%h want=%h", ras_top, 32'h1004); end
    vectors++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL jal_empty got=%b want=0", ras_empty); end
    jump_reg = 1; ret = 1; reg_target = 32'h1004;
    expQ.push_back(32'h1004);
    tick(); idle();
    want = expQ.pop_front();
    vectors++; if (pc !== want) begin errors++; $display("FAIL ret_pc got=%h want=%h", pc, want); end
    vectors++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL ret_mispredict got=%b want=0", ras_mispredict); end
    vectors++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got=%b want=1", ras_empty); end
  endtask

  task automatic test_mispredict;
    jr(32'h1000);
    jump = 1; link = 1; jump_index = 26'h40;
    tick(); idle();
    vectors++; if (ras_top !== 32'h1004) begin errors++; $display("FAIL mp_top got=%h want=%h", ras_top, 32'h1004); end
    jump_reg = 1; ret = 1; reg_target = 32'h2000;
    expQ.push_back(32'h2000); expQ.push_back(32'h2004);
    tick(); idle();
    want = expQ.pop_front();
    vectors++; if (pc !== want) begin errors++; $display("FAIL mp_pc got=%h want=%h", pc, want); end
    vectors++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL mp_pulse got=%b want=1", ras_mispredict); end
    tick();
    want = expQ.pop_front();
    vectors++; if (pc !== want) begin errors++; $display("FAIL mp_next_pc got=%h want=%h", pc, want); end
    vectors++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL mp_one_cycle got=%b want=0", ras_mispredict); end
  endtask

  task automatic test_overflow_underflow;
    jr(32'h0);
    for (int i = 0; i < 5; i++) begin
      jump = 1; link = 1; jump_index = 26'((i + 1) * 16);
      expQ.push_back(32'((i + 1) * 64));
      rasQ.push_back(32'(i * 64 + 4));
      if (rasQ.size() > 4) rasQ.delete(0);
      tick(); idle();
      want = expQ.pop_front();
      vectors++; if (pc !== want) begin errors++; $display("FAIL ovf_pc_%0d got=%h want=%h", i, pc, want); end
      vectors++; if (ras_top !== rasQ[$]) begin errors++; $display("FAIL ovf_top_%0d got=%h want=%h", i, ras_top, rasQ[$]); end
      vectors++; if (ras_overflow !== (i == 4)) begin errors++; $display("FAIL ovf_flag_%0d got=%b want=%b", i, ras_overflow, i == 4); end
    end
    for (int i = 0; i < 5; i++) begin
      want = rasQ.size() > 0 ? rasQ.pop_back() : '0;
      vectors++; if (ras_top !== want) begin errors++; $display("FAIL pop_top_%0d got=%h want=%h", i, ras_top, want); end
      jump_reg = 1; ret = 1; reg_target = want;
      tick(); idle();
      vectors++; if (ras_underflow !== (i == 4)) begin errors++; $display("FAIL unf_flag_%0d got=%b want=%b", i, ras_underflow, i == 4); end
      vectors++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL pop_mp_%0d got=%b want=0", i, ras_mispredict); end
    end
    vectors++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL unf_empty got=%b want=1", ras_empty); end
  endtask

  task automatic test_stall;
    jr(32'h1000);
    jump = 1; link = 1; jump_index = 26'h40;
    tick(); idle();
    jump = 1; link = 1; jump_index = 26'h80;
    tick(); idle();
    jump_reg = 1; ret = 1; reg_target = 32'h3000;
    tick(); idle();
    vectors++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL stall_pre_mp got=%b want=1", ras_mispredict); end
    stall = 1; jump = 1; link = 1; jump_index = 26'h3FF;
    repeat (3) expQ.push_back(32'h3000);
    for (int i = 0; i < 3; i++) begin
      tick();
      want = expQ.pop_front();
      vectors++; if (pc !== want) begin errors++; $display("FAIL stall_pc_%0d got=%h want=%h", i, pc, want); end
      vectors++; if (ras_top !== 32'h1004) begin errors++; $display("FAIL stall_top_%0d got=%h want=%h", i, ras_top, 32'h1004); end
      vectors++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL stall_mp_%0d got=%b want=0", i, ras_mispredict); end
    end
    idle();
  endtask

  task automatic test_wrap;
    jr(32'hFFFF_FFFC);
    vectors++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got=%h want=0", pc_plus4); end
    expQ.push_back(32'h0);
    tick();
    want = expQ.pop_front();
    vectors++; if (pc !== want) begin errors++; $display("FAIL wrap_pc got=%h want=%h", pc, want); end
  endtask

  task automatic test_reset_mid;
    jump = 1; jump_index = 26'h123;
    #2 rst = 1;
    #1;
    vectors++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL midrst_pc got=%h want=%h", pc, 32'h0040_0000); end
    vectors++; if ({ras_empty, ras_overflow, ras_underflow} !== 3'b100) begin errors++; $display("FAIL midrst_flags got=%b want=100", {ras_empty, ras_overflow, ras_underflow}); end
    @(negedge clk);
    idle();
    rst = 0;
    expQ.push_back(32'h0040_0004);
    tick();
    want = expQ.pop_front();
    vectors++; if (pc !== want) begin errors++; $display("FAIL midrst_seq got=%h want=%h", pc, want); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jal_ret();
    test_mispredict();
    test_overflow_underflow();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
endmodule
